// File: rtl/sc_isa_pkg.sv
// Shared ISA definitions for the single-cycle processor: opcodes,
// instruction-word field positions and the loader FSM state encoding.
package sc_isa_pkg;

    // Primary opcodes
    localparam logic [3:0] OP_ALUR = 4'b0000;
    localparam logic [3:0] OP_CMPR = 4'b0010;
    localparam logic [3:0] OP_ALUI = 4'b1000;
    localparam logic [3:0] OP_CMPI = 4'b1010;
    localparam logic [3:0] OP_BR   = 4'b0110;
    localparam logic [3:0] OP_LW   = 4'b1001;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_JAL  = 4'b1011;

    // Field LSB positions inside the 32-bit word
    localparam int F_RD_LSB  = 28;
    localparam int F_RS1_LSB = 24;
    localparam int F_RS2_LSB = 20;
    localparam int F_IMM_LSB = 8;
    localparam int F_OP_LSB  = 4;
    localparam int F_FN_LSB  = 0;

    // Loader FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    // R-type opcodes carry rs2 instead of an immediate
    function automatic logic is_rtype_op(input logic [3:0] op);
        return (op == OP_ALUR) || (op == OP_CMPR);
    endfunction

    function automatic logic is_legal_op(input logic [3:0] op);
        return is_rtype_op(op) || (op == OP_ALUI) || (op == OP_CMPI) ||
               (op == OP_BR)   || (op == OP_LW)   || (op == OP_SW)   ||
               (op == OP_JAL);
    endfunction

endpackage

// File: rtl/sc_instr_pack.sv
// Combinational field-to-word packer with opcode legality check.
module sc_instr_pack
    import sc_isa_pkg::*;
(
    input  logic [3:0]  opcode_i,
    input  logic [3:0]  fn_i,
    input  logic [3:0]  rd_i,
    input  logic [3:0]  rs1_i,
    input  logic [3:0]  rs2_i,
    input  logic [15:0] imm_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    // Pack fields; R-type zero-fills the 12 bits below rs2, others carry imm verbatim
    always_comb begin
        word_o = '0;
        word_o[F_RD_LSB  +: 4] = rd_i;
        word_o[F_RS1_LSB +: 4] = rs1_i;
        word_o[F_OP_LSB  +: 4] = opcode_i;
        word_o[F_FN_LSB  +: 4] = fn_i;
        if (is_rtype_op(opcode_i)) begin
            word_o[F_RS2_LSB +: 4] = rs2_i;
        end else begin
            word_o[F_IMM_LSB +: 16] = imm_i;
        end
    end

    assign legal_o = is_legal_op(opcode_i);

endmodule

// File: rtl/sc_instr_encoder.sv
// Streaming instruction encoder/loader: packs accepted field bundles and
// writes them to consecutive instruction-memory addresses from a base.
module sc_instr_encoder #(
    parameter int DBIT_SIZE      = 32,
    parameter int IMEM_ADDR_BITS = 10,
    parameter int CNT_BITS       = 10
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [IMEM_ADDR_BITS-1:0] baseAddr,
    input  logic [CNT_BITS-1:0]       wordCount,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic [3:0]                opcode,
    input  logic [3:0]                fn,
    input  logic [3:0]                rd,
    input  logic [3:0]                rs1,
    input  logic [3:0]                rs2,
    input  logic [15:0]               imm,
    output logic                      imemWrtEn,
    output logic [IMEM_ADDR_BITS-1:0] imemAddr,
    output logic [DBIT_SIZE-1:0]      imemWrtData,
    output logic                      busy,
    output logic                      done,
    output logic                      errFlag,
    output logic [CNT_BITS-1:0]       dropCount
);

    import sc_isa_pkg::*;

    state_e                    state_q, state_d;
    logic [CNT_BITS-1:0]       remain_q;
    logic [IMEM_ADDR_BITS-1:0] base_q;
    logic [IMEM_ADDR_BITS-1:0] idx_q;
    logic                      wen_q;
    logic [IMEM_ADDR_BITS-1:0] addr_q;
    logic [DBIT_SIZE-1:0]      data_q;
    logic                      err_q;
    logic [CNT_BITS-1:0]       drop_q;

    logic [31:0] packed_word;
    logic        packed_legal;
    logic        load_start;
    logic        accept;
    logic        last_accept;

    sc_instr_pack u_pack (
        .opcode_i (opcode),
        .fn_i     (fn),
        .rd_i     (rd),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .imm_i    (imm),
        .word_o   (packed_word),
        .legal_o  (packed_legal)
    );

    assign load_start  = start && (state_q == ST_IDLE);
    assign accept      = inValid && (state_q == ST_RUN);
    assign last_accept = accept && (remain_q == CNT_BITS'(1));

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (wordCount == '0) ? ST_FIN : ST_RUN;
            ST_RUN:   if (last_accept) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Load bookkeeping and registered write port; illegal bundles only bump the drop count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remain_q <= '0;
            base_q   <= '0;
            idx_q    <= '0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wen_q <= 1'b0;
            if (load_start) begin
                base_q   <= baseAddr;
                idx_q    <= '0;
                remain_q <= wordCount;
                err_q    <= 1'b0;
                drop_q   <= '0;
            end
            if (accept) begin
                remain_q <= remain_q - CNT_BITS'(1);
                if (packed_legal) begin
                    wen_q  <= 1'b1;
                    addr_q <= base_q + idx_q;
                    data_q <= packed_word;
                    idx_q  <= idx_q + IMEM_ADDR_BITS'(1);
                end else begin
                    err_q  <= 1'b1;
                    drop_q <= drop_q + CNT_BITS'(1);
                end
            end
        end
    end

    assign inReady     = (state_q == ST_RUN);
    assign busy        = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign done        = (state_q == ST_FIN);
    assign imemWrtEn   = wen_q;
    assign imemAddr    = addr_q;
    assign imemWrtData = data_q;
    assign errFlag     = err_q;
    assign dropCount   = drop_q;

endmodule
